// File: rtl/io_pkg.sv
// Shared widths, MMIO addresses and word packing for the board switch/key inputs.
package io_pkg;

  localparam int SW_W        = 18;
  localparam int BTN_W       = 4;
  localparam int BTN_EVT_LSB = 4;

  localparam logic [11:0] SW_ADDR  = 12'h900;
  localparam logic [11:0] BTN_ADDR = 12'h910;

  // Button word: pressed levels in the low nibble, sticky press events above them.
  function automatic logic [31:0] pack_btn(input logic [BTN_W-1:0] pressed,
                                           input logic [BTN_W-1:0] evt);
    logic [31:0] word;
    word = '0;
    word[BTN_W-1:0] = pressed;
    word[BTN_EVT_LSB +: BTN_W] = evt;
    return word;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One asynchronous input bit: 2-flop synchronizer, debounce counter and accepted level.
module debounce_bit #(
  parameter int   DEBOUNCE_CYC = 500000,
  parameter logic RST_LVL      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic accept
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // accept flags the cycle whose edge flips the stable level, so callers can
  // react on the same edge the level changes.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    accept   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        accept   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= RST_LVL;
      sync2_q  <= RST_LVL;
      stable_q <= RST_LVL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions board slide switches and keys into the sw/btn words read by the lsu,
// including sticky per-key press events cleared by a masked store.
module input_conditioner
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [BTN_W-1:0] btn_n_raw,
  input  logic             evt_clr,
  input  logic [BTN_W-1:0] evt_clr_mask,
  output logic [31:0]      sw,
  output logic [31:0]      btn
);

  logic [SW_W-1:0]  sw_lvl;
  logic [SW_W-1:0]  sw_acc_unused;
  logic [BTN_W-1:0] key_lvl;
  logic [BTN_W-1:0] key_acc;
  logic [BTN_W-1:0] press_set;
  logic [BTN_W-1:0] clr_sel;
  logic [BTN_W-1:0] evt_q, evt_d;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RST_LVL      (1'b0)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (sw_raw[i]),
      .level  (sw_lvl[i]),
      .accept (sw_acc_unused[i])
    );
  end

  // Keys are active-low, so they reset to the released (high) level.
  for (genvar i = 0; i < BTN_W; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RST_LVL      (1'b1)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw    (btn_n_raw[i]),
      .level  (key_lvl[i]),
      .accept (key_acc[i])
    );
  end

  // A press is an accepted flip while the key currently reads released; set wins over clear.
  always_comb begin
    press_set = key_acc & key_lvl;
    clr_sel   = evt_clr ? evt_clr_mask : '0;
    evt_d     = press_set | (evt_q & ~clr_sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign sw  = 32'(sw_lvl);
  assign btn = pack_btn(~key_lvl, evt_q);

endmodule

// File: tb/tb_input_conditioner.sv
// Randomized + directed bench for input_conditioner with a windowed reference model and scoreboard.
module tb_input_conditioner;

  localparam int DC = 4;
  localparam logic [21:0] RST_RAW = {4'hF, 18'h0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] sw_raw = 18'h3FFFF;
  logic [3:0]  btn_n_raw = 4'h0;
  logic        evt_clr = 1'b0;
  logic [3:0]  evt_clr_mask = 4'h0;
  logic [31:0] sw;
  logic [31:0] btn;

  int n_chk  = 0;
  int n_pass = 0;

  input_conditioner #(.DEBOUNCE_CYC(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_raw       (sw_raw),
    .btn_n_raw    (btn_n_raw),
    .evt_clr      (evt_clr),
    .evt_clr_mask (evt_clr_mask),
    .sw           (sw),
    .btn          (btn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a level is accepted once the raw samples seen two edges
  // late have shown it for DC consecutive edges while it differs from the
  // accepted level. Raw history is per edge, {keys, switches}.
  logic [21:0] hist[$];
  logic [21:0] m_stable;
  logic [3:0]  m_flag;
  logic [63:0] sb[$];

  always @(posedge clk) begin
    logic [21:0] nxt;
    logic [3:0]  prs_old, prs_new;
    if (rst) begin
      m_stable = RST_RAW;
      m_flag   = 4'h0;
      hist.delete();
      for (int k = 0; k < DC + 2; k++) hist.push_back(RST_RAW);
    end else begin
      nxt = m_stable;
      for (int b = 0; b < 22; b++) begin
        logic lv;
        bit   held;
        lv   = hist[hist.size()-2][b];
        held = 1'b1;
        for (int k = 0; k < DC; k++)
          if (hist[hist.size()-2-k][b] != lv) held = 1'b0;
        if (held && lv != m_stable[b]) nxt[b] = lv;
      end
      prs_old  = ~m_stable[21:18];
      prs_new  = ~nxt[21:18];
      m_flag   = (prs_new & ~prs_old) | (m_flag & ~(evt_clr ? evt_clr_mask : 4'h0));
      m_stable = nxt;
      hist.push_back({btn_n_raw, sw_raw});
      while (hist.size() > DC + 2) void'(hist.pop_front());
    end
    sb.push_back({32'(m_stable[17:0]), 24'h0, m_flag, ~m_stable[21:18]});
  end

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic [63:0] e;
      e = sb.pop_front();
      chk("sb_sw", sw, e[63:32]);
      chk("sb_btn", btn, e[31:0]);
    end
  end

  initial begin
    // Reset with every raw input active.
    repeat (2) @(negedge clk);
    chk("rst_sw", sw, 32'h0);
    chk("rst_btn", btn, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_sw", sw, 32'h0);
    chk("post_rst_btn", btn, 32'h0);
    sw_raw    = 18'h0;
    btn_n_raw = 4'hF;
    repeat (10) @(negedge clk);

    // Switch word latency.
    sw_raw = 18'h2A5F5;
    repeat (5) @(negedge clk);
    chk("sw_edge5", sw, 32'h0);
    @(negedge clk);
    chk("sw_edge6", sw, 32'h0002A5F5);

    // Bouncing key 0, then held pressed.
    btn_n_raw[0] = 1'b0; repeat (2) @(negedge clk);
    btn_n_raw[0] = 1'b1; repeat (2) @(negedge clk);
    btn_n_raw[0] = 1'b0; repeat (2) @(negedge clk);
    btn_n_raw[0] = 1'b1; repeat (2) @(negedge clk);
    btn_n_raw[0] = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("bounce_early", 32'({btn[4], btn[0]}), 32'h0);
    end
    @(negedge clk);
    chk("bounce_edge6", 32'({btn[4], btn[0]}), 32'h3);

    // Clear event 0 while key 0 is held.
    evt_clr = 1'b1; evt_clr_mask = 4'b0001;
    @(negedge clk);
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    chk("clr_flag0", 32'(btn[4]), 32'h0);
    chk("clr_keeps_lvl0", 32'(btn[0]), 32'h1);

    // Key 1 press and clear of flag 1 on the same edge.
    btn_n_raw[1] = 1'b0;
    repeat (5) @(negedge clk);
    evt_clr = 1'b1; evt_clr_mask = 4'b0010;
    @(negedge clk);
    evt_clr = 1'b0; evt_clr_mask = 4'h0;
    chk("set_beats_clr", 32'(btn[5]), 32'h1);
    chk("key1_lvl", 32'(btn[1]), 32'h1);

    // Reset abandons a pending switch change.
    sw_raw = 18'h15A0A;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_btn", btn, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("rst2_sw_hold", sw, 32'h0);
    end
    @(negedge clk);
    chk("rst2_sw_edge6", sw, 32'h00015A0A);

    // Randomized phase checked by the scoreboard.
    for (int it = 0; it < 80; it++) begin
      int hold;
      hold = $urandom_range(1, 10);
      if ($urandom_range(0, 1) == 1) sw_raw = 18'($urandom);
      if ($urandom_range(0, 1) == 1) btn_n_raw = 4'($urandom);
      rst          = ($urandom_range(0, 29) == 0);
      evt_clr      = ($urandom_range(0, 3) == 0);
      evt_clr_mask = 4'($urandom);
      repeat (hold) begin
        @(negedge clk);
        rst          = 1'b0;
        evt_clr      = ($urandom_range(0, 3) == 0);
        evt_clr_mask = 4'($urandom);
      end
    end
    evt_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYC, default 500000, meaning the number of cycles a synchronized level must hold before it is accepted (>=1; 10 ms at 50 MHz).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, shared with lsu.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sw_raw, input, 18 bits: asynchronous board slide switches, active-high.
REQ-005 SHALL have port btn_n_raw, input, 4 bits: asynchronous board keys, active-low (0 = pressed).
REQ-006 SHALL have port evt_clr, input, 1 bit: single-cycle pulse from lsu on a store to 0x910.
REQ-007 SHALL have port evt_clr_mask, input, 4 bits: the store data bits [7:4], selecting which event flags to clear.
REQ-008 SHALL have port sw, output, 32 bits: conditioned switch word driven to the lsu sw input (read at 0x900).
REQ-009 SHALL have port btn, output, 32 bits: conditioned button word driven to the lsu btn input (read at 0x910).

Function
REQ-010 SHALL pass every raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep, per bit, a stable-level register and a debounce counter of width $clog2(DEBOUNCE_CYC)+1.
REQ-012 SHALL, when the synchronized level differs from the stable level: replace the stable level and zero the counter if counter == DEBOUNCE_CYC-1; otherwise increment the counter.
REQ-013 SHALL zero the counter whenever the synchronized level equals the stable level, so any bounce shorter than DEBOUNCE_CYC is rejected and timing restarts.
REQ-014 SHALL have a fixed latency: with the first rising edge that samples a new raw level counted as edge 1, and the level held, the output changes at edge DEBOUNCE_CYC+2 and not earlier.
REQ-015 SHALL drive sw[17:0] = stable switch levels and sw[31:18] = 0.
REQ-016 SHALL drive btn[3:0] = stable pressed levels, i.e. the inverted stable key levels (1 = pressed).
REQ-017 SHALL drive btn[7:4] = sticky press-event flags, where flag i sets on the cycle stable pressed level i goes 0->1.
REQ-018 SHALL drive btn[31:8] = 0.
REQ-019 SHALL, on an evt_clr cycle, clear at the next edge every flag i whose evt_clr_mask[i] = 1, leaving all other flags unchanged.
REQ-020 SHALL give set priority when a flag's set and clear occur on the same edge: the flag ends at 1.
REQ-021 SHALL ignore evt_clr_mask when evt_clr = 0.
REQ-022 SHALL not affect btn[3:0] through clears.
REQ-023 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, while rst = 1 at an edge, set: switch synchronizers and stable levels to 0; key synchronizers and stable levels to 1 (released); all counters to 0; all event flags to 0.
REQ-025 SHALL give sw = 0 and btn = 0 from the first edge with rst = 1, regardless of raw inputs.
REQ-026 SHALL abandon any debounce in progress on reset, so a level pending before reset needs a full REQ-014 interval after rst is released.

Structure
REQ-027 SHALL place SW_W = 18, BTN_W = 4, BTN_EVT_LSB = 4, and the MMIO addresses SW_ADDR = 12'h900 and BTN_ADDR = 12'h910 in shared package io_pkg.
REQ-028 SHALL implement the synchronizer, counter and stable register for one bit as sub-module debounce_bit (parameters DEBOUNCE_CYC and reset level).
REQ-029 SHALL instantiate debounce_bit 22 times via generate.
REQ-030 SHALL keep the event flags and output packing in input_conditioner.

Verification (bench uses DEBOUNCE_CYC = 4)
REQ-031 SHALL cover: hold rst = 1 for 2 edges with sw_raw = 18'h3FFFF and btn_n_raw = 4'h0 -> sw = 0 and btn = 0 during reset and on the first edge after release.
REQ-032 SHALL cover: sw_raw 0 -> 18'h2A5F5, held -> sw = 32'h0002A5F5 at edge 6, and still 0 after edge 5.
REQ-033 SHALL cover: btn_n_raw[0] toggles 0,1,0,1 with 2-cycle phases, then holds 0 -> btn[0] and btn[4] reach 1 exactly 6 edges after the final transition, with no earlier assertion.
REQ-034 SHALL cover: with key 0 still held, pulse evt_clr with mask 4'b0001 -> btn[4] = 0 at the next edge; btn[0] stays 1.
REQ-035 SHALL cover: key 1 press event and evt_clr with mask 4'b0010 on the same edge -> btn[5] = 1.
REQ-036 SHALL cover: sw_raw changes, rst pulses for 1 edge 2 cycles later, raw held -> sw = 0 until 6 edges after rst is released, then sw equals the new value.
